ps2_key_decoder: RTL

Converts the raw PS/2 set-2 byte stream from the PS/2 receiver into debounced, held-key direction flags and a one-shot bomb-drop pulse for the Bomberman game core. It sits directly downstream of the PS/2 receiver, which delivers one byte per `rx_valid` strobe. Its outputs feed the top-level current-direction register logic (U/R/D/L) and the bomb module. It handles make, break and extended prefixes, and recovers from truncated sequences.

---
 rtl/bm_keys_pkg.sv | 56 +++++
 rtl/prefix_timer.sv | 31 +++
 rtl/ps2_key_decoder.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/bm_keys_pkg.sv
// PS/2 set-2 scan codes and decoder state encoding shared by the key decoder.
package bm_keys_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_BAT   = 8'hAA;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;

  typedef enum logic [1:0] {
    KS_IDLE    = 2'd0,
    KS_EXT     = 2'd1,
    KS_BRK     = 2'd2,
    KS_EXT_BRK = 2'd3
  } ks_state_e;

  // Bit positions inside the 4-bit direction vectors.
  localparam int DIR_UP    = 0;
  localparam int DIR_RIGHT = 1;
  localparam int DIR_DOWN  = 2;
  localparam int DIR_LEFT  = 3;

  function automatic logic [3:0] arrow_mask(input logic [7:0] code);
    logic [3:0] m;
    m = 4'b0000;
    case (code)
      SC_UP:    m = 4'b0001;
      SC_RIGHT: m = 4'b0010;
      SC_DOWN:  m = 4'b0100;
      SC_LEFT:  m = 4'b1000;
      default:  m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic [3:0] wasd_mask(input logic [7:0] code);
    logic [3:0] m;
    m = 4'b0000;
    case (code)
      SC_W:    m = 4'b0001;
      SC_D:    m = 4'b0010;
      SC_S:    m = 4'b0100;
      SC_A:    m = 4'b1000;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/prefix_timer.sv
// Saturating up-counter timing how long a prefix byte has waited for its follower.
module prefix_timer #(
  parameter int TIMEOUT_CYCLES = 2_500_000,
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic expired
);

  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear || !run) cnt_d = '0;
    else if (cnt_q != LAST) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Expiry lands exactly TIMEOUT_CYCLES cycles after the prefix was accepted.
  assign expired = run && (cnt_q == LAST);

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 byte stream -> held direction flags, bomb pulse and sequence-error pulse.
// Optional KEY_WASD_EN adds W/A/S/D as a second, independent source of direction flags.
module ps2_key_decoder #(
  parameter int TIMEOUT_CYCLES = 2_500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       key_up,
  output logic       key_right,
  output logic       key_down,
  output logic       key_left,
  output logic       bomb_pulse,
  output logic       seq_error
);
  import bm_keys_pkg::*;

  ks_state_e  state_q, state_d;
  logic [3:0] arrow_q, arrow_d;
  logic [3:0] keys_q, keys_d;
  logic       space_q, space_d;
  logic       bomb_q, bomb_d;
  logic       err_q, err_d;
  logic       tmo;
`ifdef KEY_WASD_EN
  logic [3:0] wasd_q, wasd_d;
`endif

  prefix_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .run     (state_q != KS_IDLE),
    .clear   (rx_valid),
    .expired (tmo)
  );

  always_comb begin
    state_d = state_q;
    arrow_d = arrow_q;
    space_d = space_q;
    bomb_d  = 1'b0;
    err_d   = 1'b0;
`ifdef KEY_WASD_EN
    wasd_d  = wasd_q;
`endif
    // A byte arriving on the expiry cycle takes precedence over the timeout.
    if (rx_valid) begin
      case (state_q)
        KS_IDLE: begin
          case (rx_data)
            SC_EXT:   state_d = KS_EXT;
            SC_BRK:   state_d = KS_BRK;
            SC_SPACE: begin
              bomb_d  = !space_q;
              space_d = 1'b1;
            end
            SC_BAT: begin
              arrow_d = '0;
              space_d = 1'b0;
`ifdef KEY_WASD_EN
              wasd_d  = '0;
`endif
            end
            default: begin
`ifdef KEY_WASD_EN
              wasd_d = wasd_q | wasd_mask(rx_data);
`endif
            end
          endcase
        end
        KS_EXT: begin
          case (rx_data)
            SC_BRK:  state_d = KS_EXT_BRK;
            SC_EXT:  state_d = KS_EXT;
            default: begin
              arrow_d = arrow_q | arrow_mask(rx_data);
              state_d = KS_IDLE;
            end
          endcase
        end
        KS_BRK: begin
          case (rx_data)
            SC_BRK: state_d = KS_BRK;
            SC_EXT: begin
              state_d = KS_EXT;
              err_d   = 1'b1;
            end
            SC_SPACE: begin
              space_d = 1'b0;
              state_d = KS_IDLE;
            end
            default: begin
`ifdef KEY_WASD_EN
              wasd_d = wasd_q & ~wasd_mask(rx_data);
`endif
              state_d = KS_IDLE;
            end
          endcase
        end
        default: begin
          arrow_d = arrow_q & ~arrow_mask(rx_data);
          state_d = KS_IDLE;
        end
      endcase
    end else if (tmo) begin
      state_d = KS_IDLE;
      err_d   = 1'b1;
    end
`ifdef KEY_WASD_EN
    keys_d = arrow_d | wasd_d;
`else
    keys_d = arrow_d;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= KS_IDLE;
      arrow_q <= '0;
      keys_q  <= '0;
      space_q <= 1'b0;
      bomb_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef KEY_WASD_EN
      wasd_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      arrow_q <= arrow_d;
      keys_q  <= keys_d;
      space_q <= space_d;
      bomb_q  <= bomb_d;
      err_q   <= err_d;
`ifdef KEY_WASD_EN
      wasd_q  <= wasd_d;
`endif
    end
  end

  assign key_up     = keys_q[DIR_UP];
  assign key_right  = keys_q[DIR_RIGHT];
  assign key_down   = keys_q[DIR_DOWN];
  assign key_left   = keys_q[DIR_LEFT];
  assign bomb_pulse = bomb_q;
  assign seq_error  = err_q;

endmodule
